// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit feeding the register file write port directly.
// Optional divider datapath enabled by defining MUL_DIV_UNIT_DIV_EN.
module mul_div_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  operand_a,
    input  logic [WIDTH-1:0]  operand_b,
    input  logic [ADDR_W-1:0] dest,
    output logic              busy,
    output logic              done,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [WIDTH-1:0]  wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [4:0]          count_r;
    logic [1:0]          op_r;
    logic [WIDTH-1:0]    a_r;
    logic [ADDR_W-1:0]   dest_r;
    logic [2*WIDTH-1:0]  acc_r;
    logic [2*WIDTH-1:0]  acc_next_s;
    logic [WIDTH:0]      mul_sum_s;
    logic                last_iter_s;
    logic                wb_valid_s;
    logic [WIDTH-1:0]    result_s;

    logic                busy_r;
    logic                done_r;
    logic                wb_en_r;
    logic [ADDR_W-1:0]   wb_dest_r;
    logic [WIDTH-1:0]    wb_data_r;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic [WIDTH-1:0]    b_r;
    logic [WIDTH-1:0]    rem_r;
    logic [WIDTH-1:0]    rem_next_s;
    logic [WIDTH-1:0]    quo_r;
    logic [WIDTH-1:0]    quo_next_s;
    logic [WIDTH:0]      shifted_s;
    logic                ge_s;
`endif

    assign last_iter_s = (state_r == RUN) && (count_r == 5'd31);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (count_r == 5'd31) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Shift-add step: add multiplicand into the upper half when the LSB is set, then shift right
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + ({1'b0, a_r} & {(WIDTH+1){acc_r[0]}});
        acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    // Restoring division step; a zero divisor naturally yields all-ones quotient and remainder = dividend
    always_comb begin
        shifted_s  = {rem_r, quo_r[WIDTH-1]};
        ge_s       = (shifted_s >= {1'b0, b_r});
        if (ge_s) begin
            rem_next_s = shifted_s[WIDTH-1:0] - b_r;
        end else begin
            rem_next_s = shifted_s[WIDTH-1:0];
        end
        quo_next_s = {quo_r[WIDTH-2:0], ge_s};
    end
`endif

    // Final-result selection, taken from the values the last iteration produces
    always_comb begin
        result_s = {WIDTH{1'b0}};
        case (op_r)
            2'b00: result_s = acc_next_s[WIDTH-1:0];
            2'b01: result_s = acc_next_s[2*WIDTH-1:WIDTH];
`ifdef MUL_DIV_UNIT_DIV_EN
            2'b10: result_s = quo_next_s;
            2'b11: result_s = rem_next_s;
`else
            2'b10: result_s = {WIDTH{1'b0}};
            2'b11: result_s = {WIDTH{1'b0}};
`endif
            default: result_s = {WIDTH{1'b0}};
        endcase
`ifdef MUL_DIV_UNIT_DIV_EN
        wb_valid_s = 1'b1;
`else
        wb_valid_s = ~op_r[1];
`endif
    end

    // Operand capture and per-iteration datapath state
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 5'd0;
            op_r    <= 2'b00;
            a_r     <= {WIDTH{1'b0}};
            dest_r  <= {ADDR_W{1'b0}};
            acc_r   <= {(2*WIDTH){1'b0}};
        end else if ((state_r == IDLE) && start) begin
            count_r <= 5'd0;
            op_r    <= op;
            a_r     <= operand_a;
            dest_r  <= dest;
            acc_r   <= {{WIDTH{1'b0}}, operand_b};
        end else if (state_r == RUN) begin
            count_r <= count_r + 5'd1;
            acc_r   <= acc_next_s;
        end else begin
            count_r <= count_r;
            acc_r   <= acc_r;
        end
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    // Divider state: quotient register starts as the dividend and fills from the LSB
    always_ff @(posedge clk) begin
        if (reset) begin
            b_r   <= {WIDTH{1'b0}};
            rem_r <= {WIDTH{1'b0}};
            quo_r <= {WIDTH{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            b_r   <= operand_b;
            rem_r <= {WIDTH{1'b0}};
            quo_r <= operand_a;
        end else if (state_r == RUN) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
        end else begin
            rem_r <= rem_r;
            quo_r <= quo_r;
        end
    end
`endif

    // Registered outputs; writeback fields hold their last value outside DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            wb_en_r   <= 1'b0;
            wb_dest_r <= {ADDR_W{1'b0}};
            wb_data_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    busy_r  <= start;
                    done_r  <= 1'b0;
                    wb_en_r <= 1'b0;
                end
                RUN: begin
                    if (last_iter_s) begin
                        done_r    <= 1'b1;
                        wb_en_r   <= wb_valid_s && (dest_r != {ADDR_W{1'b0}});
                        wb_dest_r <= dest_r;
                        wb_data_r <= result_s;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    wb_en_r <= 1'b0;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    wb_en_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign wb_en   = wb_en_r;
    assign wb_dest = wb_dest_r;
    assign wb_data = wb_data_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: latency-countdown model plus directed vectors.
// Expectations for DIVU/REMU follow MUL_DIV_UNIT_DIV_EN.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  dest;
    logic        busy;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

`ifdef MUL_DIV_UNIT_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    mul_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .dest(dest),
        .busy(busy), .done(done), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: return !DIV_ON ? 32'd0 : (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            default: return !DIV_ON ? 32'd0 : (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Model: a request in idle makes the unit busy for 33 cycles; the last one is the writeback cycle
    int          m_cyc = 0;
    logic [31:0] m_res = 32'd0, m_wd = 32'd0;
    logic [4:0]  m_dst = 5'd0, m_wdest = 5'd0;
    logic        m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_cyc   <= 0;
            m_wd    <= 32'd0;
            m_wdest <= 5'd0;
        end else if (m_cyc == 0) begin
            if (start) begin
                m_cyc   <= 33;
                m_res   <= model_res(op, operand_a, operand_b);
                m_dst   <= dest;
                m_valid <= DIV_ON || !op[1];
            end
        end else begin
            m_cyc <= m_cyc - 1;
            if (m_cyc == 2) begin
                m_wd    <= m_res;
                m_wdest <= m_dst;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_cyc != 0});
            chk("done", {31'd0, done}, {31'd0, m_cyc == 1});
            chk("wb_en", {31'd0, wb_en}, {31'd0, (m_cyc == 1) && (m_dst != 5'd0) && m_valid});
            chk("wb_dest", {27'd0, wb_dest}, {27'd0, m_wdest});
            chk("wb_data", wb_data, m_wd);
        end
    end

    // Issue one op at the current negedge, wait for done, check literal result and latency
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] d, input logic [31:0] exp_data, input logic exp_en,
                          input bit pulse_start);
        int n;
        start = 1'b1; op = o; operand_a = a; operand_b = b; dest = d;
        @(negedge clk);
        n = 1;
        while (!done && n < 40) begin
            if (pulse_start && (n == 5 || n == 20)) begin
                start = 1'b1; op = 2'd0; operand_a = 32'd3; operand_b = 32'd3; dest = 5'd1;
            end else begin
                start = 1'b0;
                op = 2'($urandom_range(3)); operand_a = $urandom; operand_b = $urandom;
                dest = 5'($urandom_range(31));
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", n, 33);
        chk("lit_data", wb_data, exp_data);
        chk("lit_en", {31'd0, wb_en}, {31'd0, exp_en});
        chk("lit_dest", {27'd0, wb_dest}, {27'd0, d});
        @(negedge clk);
        chk("lit_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int dn;
        reset = 1'b1; start = 1'b0; op = 2'd0; operand_a = 32'd0; operand_b = 32'd0; dest = 5'd0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_data", wb_data, 32'd0);

        run_op(2'd0, 32'd7, 32'd6, 5'd3, 32'd42, 1'b1, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op(2'd1, 32'h8000_0000, 32'd4, 5'd8, 32'd2, 1'b1, 1'b0);
        run_op(2'd2, 32'd100, 32'd7, 5'd5, DIV_ON ? 32'd14 : 32'd0, DIV_ON, 1'b0);
        run_op(2'd3, 32'd100, 32'd7, 5'd5, DIV_ON ? 32'd2 : 32'd0, DIV_ON, 1'b0);
        run_op(2'd2, 32'd9, 32'd0, 5'd6, DIV_ON ? 32'hFFFF_FFFF : 32'd0, DIV_ON, 1'b0);
        run_op(2'd3, 32'd9, 32'd0, 5'd6, DIV_ON ? 32'd9 : 32'd0, DIV_ON, 1'b0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'h10, 5'd31, DIV_ON ? 32'h0FFF_FFFF : 32'd0, DIV_ON, 1'b0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'h10, 5'd31, DIV_ON ? 32'hF : 32'd0, DIV_ON, 1'b0);
        run_op(2'd0, 32'd5, 32'd5, 5'd0, 32'd25, 1'b0, 1'b0);
        run_op(2'd0, 32'd1000, 32'd1000, 5'd9, 32'h000F_4240, 1'b1, 1'b1);

        // Abort a multiply mid-run with reset; nothing may be written back
        start = 1'b1; op = 2'd0; operand_a = 32'd11; operand_b = 32'd13; dest = 5'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || wb_en) dn++;
        end
        chk("abort_no_wb", dn, 0);
        run_op(2'd0, 32'd3, 32'd4, 5'd2, 32'd12, 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
